arch_state_dump: RTL and testbench

- Debug block that sits directly downstream of single_cycle_cpu and consumes its architectural state.
- After a programmable cycle count, or on an explicit start pulse, it freezes the CPU.
- It then walks the register file (32 x 64b) followed by data memory (8 x 64b) through the CPU debug read ports.
- It emits one record per entry on a valid/ready stream, which a report writer or UART drains. In silicon this replaces the bench-side end-of-run dump.

---
 rtl/arch_state_dump_if.sv | 35 +++
 rtl/arch_state_dump.sv | 185 ++++++++++++++++++
 tb/tb_arch_state_dump.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/arch_state_dump_if.sv
// rtl/arch_state_dump_if.sv - record stream bundle between the state dumper and its consumer
//
// Purpose: carries one architectural-state record per handshake from
//          arch_state_dump (master) to a report writer or UART (slave).
// Signals:
//   out_valid   master -> slave  record available
//   out_ready   slave  -> master consumer accepts record
//   out_is_mem  master -> slave  0 = register file record, 1 = data memory record
//   out_idx     master -> slave  entry index (memory records use [2:0])
//   out_data    master -> slave  entry value
interface arch_state_dump_if #(
    parameter int XLEN = 64
) ();
    logic            out_valid;
    logic            out_ready;
    logic            out_is_mem;
    logic [4:0]      out_idx;
    logic [XLEN-1:0] out_data;

    modport master (
        output out_valid,
        output out_is_mem,
        output out_idx,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_is_mem,
        input  out_idx,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/arch_state_dump.sv
// rtl/arch_state_dump.sv - freezes the CPU and streams out register file and data memory contents
//
// Purpose: after DUMP_CYCLE clock edges (when AUTO_EN) or on a start pulse,
//          stall the CPU and walk its register file and then its data memory
//          through the debug read ports, emitting one record per entry.
// Ports:
//   clk            in   system clock, rising edge
//   reset_b        in   asynchronous active-low reset
//   start          in   single-cycle dump request (honoured only in IDLE)
//   cpu_freeze     out  stalls the CPU while high
//   rf_dbg_addr    out  register file debug read address
//   rf_dbg_data    in   combinational register file read data
//   dmem_dbg_addr  out  data memory debug read address (doubleword index)
//   dmem_dbg_data  in   combinational data memory read data
//   rec            --   record stream, master side
//   busy           out  a dump is in progress (RF, MEM or DRAIN)
//   done           out  dump complete; held until reset
module arch_state_dump #(
    parameter int NUM_RF     = 32,
    parameter int NUM_DMEM   = 8,
    parameter int XLEN       = 64,
    parameter int DUMP_CYCLE = 20,
    parameter int AUTO_EN    = 1
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 start,
    output logic                 cpu_freeze,
    output logic [4:0]           rf_dbg_addr,
    input  logic [XLEN-1:0]      rf_dbg_data,
    output logic [2:0]           dmem_dbg_addr,
    input  logic [XLEN-1:0]      dmem_dbg_data,
    arch_state_dump_if.master    rec,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RF    = 3'd1,
        S_MEM   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [4:0]  RF_LAST  = 5'(NUM_RF - 1);
    localparam logic [4:0]  MEM_LAST = 5'(NUM_DMEM - 1);
    localparam logic [15:0] CNT_TRIG = 16'(DUMP_CYCLE - 1);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;
    localparam logic        AUTO     = (AUTO_EN != 0);

    state_t          state_q,   state_d;
    logic [15:0]     cnt_q,     cnt_d;
    logic [4:0]      idx_q,     idx_d;
    logic            valid_q,   valid_d;
    logic            is_mem_q,  is_mem_d;
    logic [4:0]      oidx_q,    oidx_d;
    logic [XLEN-1:0] data_q,    data_d;
    logic            freeze_q,  freeze_d;
    logic            done_q,    done_d;

    logic            load;
    logic            trigger;

    // State register: everything clears asynchronously, so a record in flight
    // is dropped and the CPU is released the moment reset_b falls.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            is_mem_q <= 1'b0;
            oidx_q   <= '0;
            data_q   <= '0;
            freeze_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            is_mem_q <= is_mem_d;
            oidx_q   <= oidx_d;
            data_q   <= data_d;
            freeze_q <= freeze_d;
            done_q   <= done_d;
        end
    end

    // Output register is refilled whenever it is empty or its current record
    // is being taken this cycle; this gives one record per cycle under a
    // permanently ready consumer and holds the record steady under backpressure.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        is_mem_d = is_mem_q;
        oidx_d   = oidx_q;
        data_d   = data_q;
        freeze_d = freeze_q;
        done_d   = done_q;

        load     = !valid_q || rec.out_ready;
        // A start coinciding with the auto-trigger still yields one dump,
        // because both simply OR into the same IDLE->RF transition.
        trigger  = start || (AUTO && (cnt_q == CNT_TRIG));

        case (state_q)
            S_IDLE: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (trigger) begin
                    state_d  = S_RF;
                    idx_d    = '0;
                    freeze_d = 1'b1;
                end
            end

            S_RF: begin
                if (load) begin
                    data_d   = rf_dbg_data;
                    oidx_d   = idx_q;
                    is_mem_d = 1'b0;
                    valid_d  = 1'b1;
                    if (idx_q == RF_LAST) begin
                        idx_d   = '0;
                        state_d = S_MEM;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end

            S_MEM: begin
                if (load) begin
                    data_d   = dmem_dbg_data;
                    oidx_d   = {2'b00, idx_q[2:0]};
                    is_mem_d = 1'b1;
                    valid_d  = 1'b1;
                    if (idx_q == MEM_LAST) begin
                        idx_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end

            // Final record sits in the output register; the CPU stays frozen
            // until it is accepted so the dump is a consistent snapshot.
            S_DRAIN: begin
                if (rec.out_ready) begin
                    valid_d  = 1'b0;
                    freeze_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end

            // Terminal: start and the cycle counter are ignored until reset.
            S_DONE: begin
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rf_dbg_addr    = idx_q;
    assign dmem_dbg_addr  = idx_q[2:0];

    assign rec.out_valid  = valid_q;
    assign rec.out_is_mem = is_mem_q;
    assign rec.out_idx    = oidx_q;
    assign rec.out_data   = data_q;

    assign cpu_freeze     = freeze_q;
    assign done           = done_q;
    assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_arch_state_dump.sv
// tb/tb_arch_state_dump.sv - self-checking bench for arch_state_dump
module tb_arch_state_dump;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_b;
    logic            start_a, start_m;
    logic            frz_a, frz_m, busy_a, busy_m, done_a, done_m;
    logic [4:0]      rfa_a, rfa_m;
    logic [2:0]      dma_a, dma_m;
    logic [XLEN-1:0] rfd_a, rfd_m, dmd_a, dmd_m;
    logic            rdy;
    logic            cpu_we;
    logic            sel;

    logic [XLEN-1:0] rf   [32];
    logic [XLEN-1:0] dmem [8];

    arch_state_dump_if #(.XLEN(XLEN)) if_a ();
    arch_state_dump_if #(.XLEN(XLEN)) if_m ();

    assign if_a.out_ready = rdy;
    assign if_m.out_ready = rdy;

    // CPU model: state is loaded during reset; a write-back to x5 is gated
    // by the auto instance's freeze, exactly as the real CPU would be.
    always @(posedge clk) begin
        if (!reset_b) begin
            for (int i = 0; i < 32; i++) rf[i] <= 64'(i) * 64'h1111;
            for (int j = 0; j < 8; j++)  dmem[j] <= 64'hA0 + 64'(j);
        end else if (cpu_we && !frz_a) begin
            rf[5] <= 64'hDEAD;
        end
    end

    assign rfd_a = rf[rfa_a];
    assign rfd_m = rf[rfa_m];
    assign dmd_a = dmem[dma_a];
    assign dmd_m = dmem[dma_m];

    arch_state_dump #(.NUM_RF(32), .NUM_DMEM(8), .XLEN(XLEN), .DUMP_CYCLE(20), .AUTO_EN(1)) dut_a (
        .clk(clk), .reset_b(reset_b), .start(start_a), .cpu_freeze(frz_a),
        .rf_dbg_addr(rfa_a), .rf_dbg_data(rfd_a), .dmem_dbg_addr(dma_a), .dmem_dbg_data(dmd_a),
        .rec(if_a), .busy(busy_a), .done(done_a)
    );

    arch_state_dump #(.NUM_RF(32), .NUM_DMEM(8), .XLEN(XLEN), .DUMP_CYCLE(20), .AUTO_EN(0)) dut_m (
        .clk(clk), .reset_b(reset_b), .start(start_m), .cpu_freeze(frz_m),
        .rf_dbg_addr(rfa_m), .rf_dbg_data(rfd_m), .dmem_dbg_addr(dma_m), .dmem_dbg_data(dmd_m),
        .rec(if_m), .busy(busy_m), .done(done_m)
    );

    logic            s_valid, s_mem, s_frz, s_busy, s_done;
    logic [4:0]      s_idx;
    logic [XLEN-1:0] s_data;
    assign s_valid = sel ? if_m.out_valid  : if_a.out_valid;
    assign s_mem   = sel ? if_m.out_is_mem : if_a.out_is_mem;
    assign s_idx   = sel ? if_m.out_idx    : if_a.out_idx;
    assign s_data  = sel ? if_m.out_data   : if_a.out_data;
    assign s_frz   = sel ? frz_m  : frz_a;
    assign s_busy  = sel ? busy_m : busy_a;
    assign s_done  = sel ? done_m : done_a;

    typedef struct {
        bit         manual;
        logic [3:0] rdy_pat;
        int         s1;
        int         s2;
        bit         cpu_wr;
        int         exp_frz_edge;
        int         exp_n;
    } vec_t;

    vec_t vecs [5];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_data(input int k);
        if (k < 32) return 64'(k) * 64'h1111;
        return 64'hA0 + 64'(k - 32);
    endfunction

    task automatic do_reset();
        reset_b = 1'b0;
        start_a = 1'b0;
        start_m = 1'b0;
        rdy     = 1'b0;
        cpu_we  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid",  s_valid, 0);
        chk("rst_idx",    s_idx,   0);
        chk("rst_is_mem", s_mem,   0);
        chk("rst_data",   s_data,  0);
        chk("rst_freeze", s_frz,   0);
        chk("rst_busy",   s_busy,  0);
        chk("rst_done",   s_done,  0);
        reset_b = 1'b1;
    endtask

    // Assumes reset_b was just released on a falling edge; edge e counts
    // rising edges since then, and outputs are sampled on the falling edge.
    task automatic run_stream(input vec_t v);
        int              e = 0;
        int              k = 0;
        int              frz_e = -1;
        int              done_e = -1;
        int              quiet_bad = 0;
        bit              hold = 0;
        bit              r;
        bit              s;
        logic [63:0]     hd;
        logic [4:0]      hi;
        logic            hm;
        sel = v.manual;
        while (done_e < 0 && e < 400) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (s_frz && frz_e < 0) begin
                frz_e = e;
                chk("freeze_edge", e, v.exp_frz_edge);
                chk("busy_at_freeze", s_busy, 1);
            end
            if (hold) begin
                chk("stall_valid", s_valid, 1);
                chk("stall_data",  s_data,  hd);
                chk("stall_idx",   s_idx,   hi);
                chk("stall_mem",   s_mem,   hm);
            end
            if (s_done) begin
                done_e = e;
                chk("done_freeze_clear", s_frz,  0);
                chk("done_busy_clear",   s_busy, 0);
                chk("done_valid_clear",  s_valid, 0);
                chk("record_count",      k, v.exp_n);
                if (v.rdy_pat == 4'hF) chk("done_edge", e, v.exp_frz_edge + 41);
            end
            r = v.rdy_pat[3 - (e % 4)];
            rdy = r;
            s = (e + 1 == v.s1) || (e + 1 == v.s2);
            start_a = v.manual ? 1'b0 : s;
            start_m = v.manual ? s : 1'b0;
            cpu_we  = v.cpu_wr && (k >= 1);
            if (s_valid && r) begin
                chk("rec_idx",    s_idx,  (k < 32) ? k : k - 32);
                chk("rec_is_mem", s_mem,  (k >= 32) ? 1 : 0);
                chk("rec_data",   s_data, exp_data(k));
                if (v.rdy_pat == 4'hF) chk("rec_edge", e, v.exp_frz_edge + 1 + k);
                k++;
            end
            hold = s_valid && !r;
            hd = s_data;
            hi = s_idx;
            hm = s_mem;
        end
        if (done_e < 0) chk("timeout_done", 0, 1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            rdy = 1'b1;
            start_a = v.manual ? 1'b0 : (i % 5 == 0);
            start_m = v.manual ? (i % 5 == 0) : 1'b0;
            if (s_valid || s_frz || !s_done) quiet_bad++;
        end
        start_a = 1'b0;
        start_m = 1'b0;
        cpu_we  = 1'b0;
        chk("post_done_quiet", quiet_bad, 0);
    endtask

    initial begin
        int n;
        sel     = 1'b0;
        reset_b = 1'b0;
        start_a = 1'b0;
        start_m = 1'b0;
        rdy     = 1'b0;
        cpu_we  = 1'b0;

        //          manual rdy_pat  s1  s2  cpu_wr frz  n
        vecs[0] = '{1'b0, 4'b1111, -1, -1, 1'b0,  20, 40};
        vecs[1] = '{1'b0, 4'b1001, -1, -1, 1'b0,  20, 40};
        vecs[2] = '{1'b1, 4'b1111,  5, 10, 1'b0,   5, 40};
        vecs[3] = '{1'b0, 4'b1111, -1, -1, 1'b1,  20, 40};
        vecs[4] = '{1'b0, 4'b1111, 20, 25, 1'b0,  20, 40};

        for (int i = 0; i < 5; i++) begin
            do_reset();
            run_stream(vecs[i]);
        end

        // RF31 -> MEM0 boundary held under backpressure.
        do_reset();
        sel = 1'b0;
        rdy = 1'b1;
        n = 0;
        while (!(s_valid && s_idx == 5'd31 && !s_mem) && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("bnd_reached", (n < 200) ? 1 : 0, 1);
        rdy = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("bnd_hold_valid", s_valid, 1);
            chk("bnd_hold_idx",   s_idx,   31);
            chk("bnd_hold_mem",   s_mem,   0);
            chk("bnd_hold_data",  s_data,  exp_data(31));
        end
        rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bnd_next_valid", s_valid, 1);
        chk("bnd_next_idx",   s_idx,   0);
        chk("bnd_next_mem",   s_mem,   1);
        chk("bnd_next_data",  s_data,  64'hA0);

        // Reset pulsed during record RF12: async clear, then a full restart.
        do_reset();
        sel = 1'b0;
        rdy = 1'b1;
        n = 0;
        while (!(s_valid && s_idx == 5'd12 && !s_mem) && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("mid_reached", (n < 200) ? 1 : 0, 1);
        reset_b = 1'b0;
        #1;
        chk("mid_rst_valid",  s_valid, 0);
        chk("mid_rst_freeze", s_frz,   0);
        chk("mid_rst_busy",   s_busy,  0);
        chk("mid_rst_done",   s_done,  0);
        chk("mid_rst_idx",    s_idx,   0);
        chk("mid_rst_data",   s_data,  0);
        @(negedge clk);
        reset_b = 1'b1;
        run_stream(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "bench timeout");
    end
endmodule
